// File: rtl/complex_mul.sv
// complex_mul: pipelined fixed-point complex multiplier. Each 64x64 product is split into 32x32 partials,
// then summed and floor-scaled by FRAC; a delay line pads the pipeline to LATENCY.
module complex_mul #(
  parameter int BIT = 128,
  parameter int FRAC = 32,
  parameter int LATENCY = 30
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [BIT-1:0] num1,
  input  logic [BIT-1:0] num2,
  input  logic           valid,
  output logic [BIT-1:0] result,
  output logic           ready
);
  localparam int H = BIT / 2;
  localparam int Q = H / 2;
  localparam int PW = H + FRAC;
  logic [H-1:0] x [4];
  logic [H-1:0] y [4];
  logic signed [Q:0] xh [4];
  logic signed [Q:0] xl [4];
  logic signed [Q:0] yh [4];
  logic signed [Q:0] yl [4];
  logic signed [2*Q+1:0] pp [4][4];
  logic [PW-1:0] p [4];
  logic [BIT-1:0] dl [LATENCY-3];
  logic [LATENCY-1:0] vs;
  // Product order: Xr*Yr, Xi*Yi, Xr*Yi, Xi*Yr. High halves carry the sign; low halves are unsigned.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      xh[k] = $signed({x[k][H-1], x[k][H-1:Q]});
      xl[k] = $signed({1'b0, x[k][Q-1:0]});
      yh[k] = $signed({y[k][H-1], y[k][H-1:Q]});
      yl[k] = $signed({1'b0, y[k][Q-1:0]});
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        x[k] <= '0;
        y[k] <= '0;
        p[k] <= '0;
        for (int j = 0; j < 4; j++) pp[k][j] <= '0;
      end
      for (int i = 0; i < LATENCY - 3; i++) dl[i] <= '0;
      vs <= '0;
    end else begin
      x[0] <= num1[BIT-1:H];
      y[0] <= num2[BIT-1:H];
      x[1] <= num1[H-1:0];
      y[1] <= num2[H-1:0];
      x[2] <= num1[BIT-1:H];
      y[2] <= num2[H-1:0];
      x[3] <= num1[H-1:0];
      y[3] <= num2[BIT-1:H];
      for (int k = 0; k < 4; k++) begin
        pp[k][0] <= xh[k] * yh[k];
        pp[k][1] <= xh[k] * yl[k];
        pp[k][2] <= xl[k] * yh[k];
        pp[k][3] <= xl[k] * yl[k];
        // Only the low H+FRAC product bits can reach the scaled output, so wider sums are unnecessary.
        p[k] <= (PW'(pp[k][0]) << (2 * Q)) + ((PW'(pp[k][1]) + PW'(pp[k][2])) << Q) + PW'(pp[k][3]);
      end
      dl[0] <= {H'((p[0] - p[1]) >> FRAC), H'((p[2] + p[3]) >> FRAC)};
      for (int i = 1; i < LATENCY - 3; i++) dl[i] <= dl[i-1];
      vs <= {vs[LATENCY-2:0], valid};
    end
  end
  assign result = dl[LATENCY-4];
  assign ready = vs[LATENCY-1];
endmodule

// File: tb/tb_complex_mul.sv
// tb_complex_mul: directed vectors with hand-computed products plus a free-running
// golden model that checks result/ready every cycle through streaming, reset and bubbles.
module tb_complex_mul;
  logic clk = 0;
  logic rst = 1;
  logic [127:0] num1 = '0;
  logic [127:0] num2 = '0;
  logic valid = 0;
  logic [127:0] result;
  logic ready;
  int n_chk = 0;
  int n_err = 0;
  int rdy_cnt = 0;
  bit mon = 0;
  logic [127:0] m_d [30];
  logic m_v [30];

  complex_mul dut (.clk(clk), .rst(rst), .num1(num1), .num2(num2), .valid(valid), .result(result), .ready(ready));

  always #5 clk = ~clk;

  function automatic logic [127:0] golden(input logic [127:0] a, input logic [127:0] b);
    logic signed [128:0] xr, xi, yr, yi, pr, pi;
    xr = 129'($signed(a[127:64]));
    xi = 129'($signed(a[63:0]));
    yr = 129'($signed(b[127:64]));
    yi = 129'($signed(b[63:0]));
    pr = xr * yr - xi * yi;
    pi = xr * yi + xi * yr;
    return {pr[95:32], pi[95:32]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference pipeline: each edge pushes the ideal product of the sampled inputs.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 30; i++) begin
        m_d[i] <= '0;
        m_v[i] <= 1'b0;
      end
    end else begin
      for (int i = 29; i > 0; i--) begin
        m_d[i] <= m_d[i-1];
        m_v[i] <= m_v[i-1];
      end
      m_d[0] <= golden(num1, num2);
      m_v[0] <= valid;
    end
  end

  always @(negedge clk) begin
    if (mon) begin
      chk("stream_result", result, m_d[29]);
      chk("stream_ready", 128'(ready), 128'(m_v[29]));
      if (ready) rdy_cnt++;
    end
  end

  task automatic step(input logic [127:0] n1, input logic [127:0] n2, input logic v);
    @(negedge clk);
    num1 = n1;
    num2 = n2;
    valid = v;
  endtask

  task automatic apply_one(input string tag, input logic [127:0] n1, input logic [127:0] n2, input logic [127:0] exp);
    step(n1, n2, 1'b1);
    repeat (29) step('0, '0, 1'b0);
    @(negedge clk);
    chk(tag, result, exp);
    chk({tag, "_ready"}, 128'(ready), 128'(1));
  endtask

  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    mon = 1;
    @(negedge clk);
    chk("reset_result", result, '0);
    chk("reset_ready", 128'(ready), '0);
    rst = 0;
    apply_one("basic", {64'h0000000100000000, 64'h0000000200000000},
              {64'h0000000300000000, 64'h0000000400000000},
              {64'hFFFFFFFB00000000, 64'h0000000A00000000});
    apply_one("trunc_pos", {64'h0000000000000001, 64'h0}, {64'h0000000080000000, 64'h0}, '0);
    apply_one("trunc_neg", {64'hFFFFFFFFFFFFFFFF, 64'h0}, {64'h0000000080000000, 64'h0},
              {64'hFFFFFFFFFFFFFFFF, 64'h0});
    apply_one("wrap", {64'h0001000000000000, 64'h0}, {64'h0001000000000000, 64'h0}, '0);
    apply_one("neg_imag", {64'h0, 64'hFFFFFFFF00000000}, {64'h0, 64'h0000000200000000},
              {64'h0000000200000000, 64'h0});
    repeat (3) step('0, '0, 1'b0);
    @(negedge clk);
    rdy_cnt = 0;
    for (int i = 0; i < 1000; i++) step(rnd(), rnd(), 1'b1);
    repeat (35) step('0, '0, 1'b0);
    @(negedge clk);
    chk("stream_ready_count", 128'(rdy_cnt), 128'(1000));
    chk("stream_drain_result", result, '0);
    for (int i = 0; i < 10; i++) step(rnd(), rnd(), 1'b1);
    @(negedge clk);
    num1 = '0;
    num2 = '0;
    valid = 0;
    rst = 1;
    #1;
    chk("midreset_result", result, '0);
    chk("midreset_ready", 128'(ready), '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    rdy_cnt = 0;
    for (int i = 0; i < 10; i++) step(rnd(), rnd(), 1'b1);
    repeat (35) step('0, '0, 1'b0);
    @(negedge clk);
    chk("postreset_ready_count", 128'(rdy_cnt), 128'(10));
    rdy_cnt = 0;
    for (int i = 0; i < 20; i++) step(rnd(), rnd(), (i % 2) == 0);
    repeat (35) step('0, '0, 1'b0);
    @(negedge clk);
    chk("bubble_ready_count", 128'(rdy_cnt), 128'(10));
    mon = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
